ili9341_spi_writer: RTL and testbench
=====================================

# ili9341_spi_writer

Buffered SPI byte writer for the ILI9341 panel; the serial stage directly downstream of the panel initialiser and any later pixel/command source. Accepts command/data bytes over a valid/ready interface into a small FIFO, then drives tft_cs, tft_dc, tft_clk and tft_din. Bytes are shifted MSB-first in mode 0. Consecutive queued bytes are streamed with CS held low and no SCLK gap.

## Interface
- CLK_DIV, default 1: SCLK half-period in clk cycles; legal range ≥1.
- FIFO_DEPTH, default 16: byte FIFO entries; power of two, ≥2.
- CS_HOLD, default 2: clk cycles CS stays low after the last SCLK falling edge before deasserting.
- clk  in  1  block clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- wr_valid  in  1  producer offers a byte.
- wr_ready  out  1  FIFO can accept; a write occurs when wr_valid and wr_ready are both high.
- wr_dc  in  1  0 = command byte, 1 = data/parameter byte.
- wr_byte  in  8  byte to send.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- tft_cs  out  1  panel chip select, active-low.
- tft_dc  out  1  panel D/C line.
- tft_clk  out  1  SCLK, idles low.
- tft_din  out  1  serial data, MSB first.

## Operation
- FIFO: 9-bit entries {dc, byte}. wr_ready = !full, registered from the level. Push and pop in the same cycle are both performed and the level is unchanged. A write offered while wr_ready=0 is ignored.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE: tft_cs=1, tft_clk=0. On FIFO non-empty: pop, load the shift register, latch dc, go to SHIFT.
- SHIFT, per bit:
  - Low phase of CLK_DIV cycles: tft_clk=0, tft_din=current bit.
  - High phase of CLK_DIV cycles: tft_clk=1. The panel samples on the rising edge.
  - Bit counter counts 7 down to 0.
- End of bit 0 high phase, FIFO non-empty: pop and continue SHIFT with the new byte. CS stays low and the next low phase starts in the following cycle. tft_dc updates at the start of the new byte's low phase.
- End of bit 0 high phase, FIFO empty: go to HOLD with tft_clk=0 and CS still low.
- HOLD: counts CS_HOLD cycles, then tft_cs=1 and the FSM returns to IDLE. If the FIFO becomes non-empty during HOLD: pop, go to SHIFT, and CS never rises.
- tft_dc and tft_din hold their last values while in IDLE.
- Reset mid-operation: FIFO flushed, partial byte abandoned, and all outputs take their reset values at the next clk edge.

## Timing
- Reset values: tft_cs=1, tft_clk=0, tft_din=0, tft_dc=0, wr_ready=1, busy=0, fifo_level=0.
- Write accepted at edge N, FSM in IDLE:
  - fifo_level=1 during cycle N+1; the FSM pops at the end of N+1.
  - tft_cs=0 with valid tft_dc and tft_din=bit7 from cycle N+2.
  - First SCLK rising edge at N+2+CLK_DIV.
- Byte duration: 16*CLK_DIV cycles. Back-to-back bytes produce continuous SCLK at clk/(2*CLK_DIV).
- CS rises CS_HOLD cycles after the final falling edge.
- busy falls in the same cycle tft_cs rises.
- fifo_level is registered and reflects pushes and pops from the previous edge.

## Structure
- Shared package ili9341_pkg: FSM state enum; typedef for the {dc, byte} entry; constants DC_CMD=0 and DC_DATA=1.
- Sub-module ili9341_byte_fifo: synchronous FIFO parameterised by depth and width, providing full, empty and level.
- FSM, bit counter, phase counter and shift register live in ili9341_spi_writer.

## Test plan
- Single command, CLK_DIV=1:
  - Stimulus: write 0x2A, dc=0.
  - Response: CS low from N+2; 8 rising edges with din samples 0,0,1,0,1,0,1,0; dc=0 throughout; CS high 16+CS_HOLD cycles after N+2; busy falls with CS.
- Command plus data:
  - Stimulus: writes 0x2C dc=0, 0xF8 dc=1, 0x00 dc=1 on consecutive cycles.
  - Response: 24 contiguous SCLK periods; CS stays low; dc rises at the start of byte 2's low phase.
- Backpressure:
  - Stimulus: wr_valid held for 40 cycles with incrementing bytes.
  - Response: wr_ready drops when fifo_level=FIFO_DEPTH; the serial stream equals exactly the accepted bytes, in order.
- Write during HOLD, CS_HOLD=4:
  - Stimulus: second byte written 2 cycles after the first byte completes.
  - Response: CS never rises between the bytes.
- CLK_DIV=3:
  - Stimulus: write 0xA5.
  - Response: SCLK high/low phases of 3 cycles each; byte spans 48 cycles; din samples 1,0,1,0,0,1,0,1.
- Reset mid-byte:
  - Stimulus: assert rst after 3 bits with 5 bytes queued.
  - Response: next cycle tft_cs=1, tft_clk=0, fifo_level=0, busy=0. No further SCLK edges until a new write.

Source files
------------

// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 SPI byte writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, {dc, byte} FIFO entry type, D/C line encodings.
package ili9341_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] dat;
  } entry_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/ili9341_byte_fifo.sv
// Generic synchronous FIFO with registered occupancy level.
// Latency: a pushed entry is visible at the read port the cycle after the push.
// Backpressure: full blocks pushes; pops while empty are ignored.
// Ports: clk/rst (sync, active-high); push_vld/push_dat in; full out;
//        pop in, pop_dat out (first-word fall-through); empty, level out.
module ili9341_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push_vld && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: reset empties the FIFO via pointers and level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/ili9341_spi_writer.sv
// Buffered mode-0 SPI byte writer for the ILI9341 panel (MSB first, CS streamed).
// Latency: write at edge N -> CS low with bit7 on din from cycle N+2; byte = 16*CLK_DIV cycles.
// Backpressure: wr_ready = !full of the byte FIFO; writes offered while not ready are dropped.
// Ports: clk/rst (sync, active-high); wr_valid/wr_ready/wr_dc/wr_byte producer side;
//        fifo_level, busy status; tft_cs/tft_dc/tft_clk/tft_din panel side (all registered).
// CLK_DIV >= 1 (SCLK half-period in clk cycles), FIFO_DEPTH power of two >= 2, CS_HOLD >= 1.
module ili9341_spi_writer
  import ili9341_pkg::*;
#(
  parameter int CLK_DIV    = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int CS_HOLD    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          wr_dc,
  input  logic [7:0]                    wr_byte,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          tft_cs,
  output logic                          tft_dc,
  output logic                          tft_clk,
  output logic                          tft_din
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

  entry_t  push_ent, pop_ent;
  logic    fifo_full, fifo_empty, fifo_pop;

  state_t        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hold_q, hold_d;
  // Holds the bits still to be sent after the one currently on din.
  logic [6:0]    shift_q, shift_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          din_q, din_d;
  logic          dc_q, dc_d;
  logic          load;

  assign push_ent = '{dc: wr_dc, dat: wr_byte};

  ili9341_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (wr_valid),
    .push_dat (push_ent),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .pop_dat  (pop_ent),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign wr_ready = !fifo_full;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);
  assign tft_cs   = cs_q;
  assign tft_dc   = dc_q;
  assign tft_clk  = sclk_q;
  assign tft_din  = din_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    div_d   = div_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    dc_d    = dc_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (!fifo_empty) load = 1'b1;
      end
      ST_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = DIV_LAST;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q != '0) begin
            sclk_d  = 1'b0;
            bit_d   = bit_q - 1'b1;
            din_d   = shift_q[6];
            shift_d = {shift_q[5:0], 1'b0};
          end else if (!fifo_empty) begin
            // Chain straight into the next byte: no SCLK gap, CS stays low.
            load = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            hold_d  = HOLD_LAST;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // A byte arriving during hold restarts shifting without releasing CS.
        if (!fifo_empty) begin
          load = 1'b1;
        end else if (hold_q == '0) begin
          cs_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_SHIFT;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      dc_d    = pop_ent.dc;
      din_d   = pop_ent.dat[7];
      shift_d = pop_ent.dat[6:0];
      bit_d   = 3'd7;
      div_d   = DIV_LAST;
    end
  end

  assign fifo_pop = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      div_q   <= '0;
      hold_q  <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      dc_q    <= dc_d;
    end
  end

endmodule

// File: tb/tb_ili9341_spi_writer.sv
// Directed bench for ili9341_spi_writer: instance A (CLK_DIV=1, depth 16, CS_HOLD=4)
// and instance B (CLK_DIV=3, depth 4, CS_HOLD=2). Inputs change and outputs are
// sampled on the falling clock edge; a serial monitor rebuilds {dc, byte} from A.
module tb_ili9341_spi_writer;
  import ili9341_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, wr_valid_a = 1'b0, wr_dc_a = 1'b0;
  logic [7:0] wr_byte_a = '0;
  logic       wr_ready_a, busy_a, cs_a, dc_a, sclk_a, din_a;
  logic [4:0] fifo_level_a;

  logic       rst_b = 1'b1, wr_valid_b = 1'b0, wr_dc_b = 1'b0;
  logic [7:0] wr_byte_b = '0;
  logic       wr_ready_b, busy_b, cs_b, dc_b, sclk_b, din_b;
  logic [2:0] fifo_level_b;

  ili9341_spi_writer #(.CLK_DIV(1), .FIFO_DEPTH(16), .CS_HOLD(4)) dut_a (
    .clk(clk), .rst(rst_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .wr_dc(wr_dc_a), .wr_byte(wr_byte_a), .fifo_level(fifo_level_a), .busy(busy_a),
    .tft_cs(cs_a), .tft_dc(dc_a), .tft_clk(sclk_a), .tft_din(din_a));

  ili9341_spi_writer #(.CLK_DIV(3), .FIFO_DEPTH(4), .CS_HOLD(2)) dut_b (
    .clk(clk), .rst(rst_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .wr_dc(wr_dc_b), .wr_byte(wr_byte_b), .fifo_level(fifo_level_b), .busy(busy_b),
    .tft_cs(cs_b), .tft_dc(dc_b), .tft_clk(sclk_b), .tft_din(din_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state for instance A
  int         cyc = 0;
  logic       prev_clk = 1'b0, prev_cs = 1'b1, prev_dc = 1'b0, prev_busy = 1'b0;
  int         rise_cnt, first_rise, last_rise, cs_fall_cyc, cs_rise_cyc;
  int         cs_rise_cnt, dc_rise_cyc, busy_fall_cyc, nbits, cs_bad = 0;
  logic [7:0] sh;
  logic       byte_dc;
  logic [8:0] rx_q[$];

  task automatic mon_clear();
    rx_q.delete();
    rise_cnt = 0; first_rise = -1; last_rise = -1; cs_fall_cyc = -1;
    cs_rise_cyc = -1; cs_rise_cnt = 0; dc_rise_cyc = -1; busy_fall_cyc = -1;
    nbits = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst_a) begin
      nbits = 0;
    end else if (sclk_a && !prev_clk) begin
      rise_cnt++;
      if (first_rise < 0) first_rise = cyc;
      last_rise = cyc;
      if (cs_a) cs_bad++;
      if (nbits == 0) byte_dc = dc_a;
      sh = {sh[6:0], din_a};
      nbits++;
      if (nbits == 8) begin
        rx_q.push_back({byte_dc, sh});
        nbits = 0;
      end
    end
    if (!cs_a && prev_cs)   cs_fall_cyc = cyc;
    if (cs_a && !prev_cs)   begin cs_rise_cyc = cyc; cs_rise_cnt++; end
    if (dc_a && !prev_dc)   dc_rise_cyc = cyc;
    if (!busy_a && prev_busy) busy_fall_cyc = cyc;
    prev_clk = sclk_a; prev_cs = cs_a; prev_dc = dc_a; prev_busy = busy_a;
  endtask

  // Offer one byte to A; returns sampling the cycle after acceptance.
  task automatic write_a(input logic dc, input logic [7:0] b);
    wr_valid_a = 1'b1; wr_dc_a = dc; wr_byte_a = b;
    tick();
    wr_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int max);
    int n = 0;
    while ((busy_a || !cs_a) && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < max), 1);
  endtask

  function automatic logic [8:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 9'h1FF;
  endfunction

  initial begin
    logic [8:0] exp_q[$];
    int         bad, saw_full, saved;
    logic [7:0] got;

    mon_clear();
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Reset values
    chk("rst_cs", cs_a, 1);  chk("rst_clk", sclk_a, 0); chk("rst_din", din_a, 0);
    chk("rst_dc", dc_a, 0);  chk("rst_rdy", wr_ready_a, 1); chk("rst_busy", busy_a, 0);
    chk("rst_lvl", fifo_level_a, 0);

    // Single command 0x2A
    mon_clear();
    write_a(DC_CMD, 8'h2A);
    chk("t1_lvl_n1", fifo_level_a, 1); chk("t1_cs_n1", cs_a, 1); chk("t1_busy_n1", busy_a, 1);
    tick();
    chk("t1_cs_n2", cs_a, 0); chk("t1_din_n2", din_a, 0); chk("t1_clk_n2", sclk_a, 0);
    chk("t1_lvl_n2", fifo_level_a, 0);
    tick();
    chk("t1_clk_n3", sclk_a, 1);
    wait_idle_a(200);
    chk("t1_nbytes", rx_q.size(), 1);
    chk("t1_byte", rx_at(0), 9'h02A);
    chk("t1_rises", rise_cnt, 8);
    chk("t1_first_rise", first_rise - cs_fall_cyc, 1);
    chk("t1_cs_low_len", cs_rise_cyc - cs_fall_cyc, 20);
    chk("t1_busy_with_cs", busy_fall_cyc, cs_rise_cyc);

    // Command plus two data bytes, written on consecutive cycles
    mon_clear();
    wr_valid_a = 1'b1; wr_dc_a = DC_CMD;  wr_byte_a = 8'h2C; tick();
    wr_dc_a = DC_DATA; wr_byte_a = 8'hF8; tick();
    wr_byte_a = 8'h00; tick();
    wr_valid_a = 1'b0;
    wait_idle_a(400);
    chk("t2_nbytes", rx_q.size(), 3);
    chk("t2_b0", rx_at(0), 9'h02C);
    chk("t2_b1", rx_at(1), 9'h1F8);
    chk("t2_b2", rx_at(2), 9'h100);
    chk("t2_rises", rise_cnt, 24);
    chk("t2_contig", last_rise - first_rise, 46);
    chk("t2_cs_rises", cs_rise_cnt, 1);
    chk("t2_dc_rise", dc_rise_cyc - cs_fall_cyc, 16);

    // Backpressure: 40 cycles of offers
    mon_clear();
    bad = 0; saw_full = 0;
    for (int i = 0; i < 40; i++) begin
      wr_valid_a = 1'b1; wr_dc_a = DC_DATA; wr_byte_a = 8'(8'h40 + i);
      if (wr_ready_a) exp_q.push_back({1'b1, wr_byte_a});
      tick();
      if (fifo_level_a == 5'd16) saw_full = 1;
      if (wr_ready_a != (fifo_level_a != 5'd16)) bad++;
    end
    wr_valid_a = 1'b0;
    chk("t3_saw_full", saw_full, 1);
    chk("t3_rdy_vs_lvl", bad, 0);
    chk("t3_accepted", exp_q.size(), 19);
    wait_idle_a(1000);
    chk("t3_nbytes", rx_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (rx_at(i) !== exp_q[i]) bad++;
    chk("t3_order", bad, 0);

    // Write during HOLD (CS_HOLD=4)
    mon_clear();
    write_a(DC_CMD, 8'h11);
    repeat (17) tick();
    chk("t4_hold_cs", cs_a, 0); chk("t4_hold_clk", sclk_a, 0);
    chk("t4_hold_lvl", fifo_level_a, 0); chk("t4_hold_busy", busy_a, 1);
    tick();
    write_a(DC_DATA, 8'h22);
    wait_idle_a(200);
    chk("t4_cs_rises", cs_rise_cnt, 1);
    chk("t4_b0", rx_at(0), 9'h011);
    chk("t4_b1", rx_at(1), 9'h122);

    // CLK_DIV=3 on instance B, byte 0xA5
    wr_valid_b = 1'b1; wr_dc_b = DC_DATA; wr_byte_b = 8'hA5;
    tick();
    wr_valid_b = 1'b0;
    chk("t5_lvl_n1", fifo_level_b, 1); chk("t5_rdy", wr_ready_b, 1);
    bad = 0; got = '0;
    for (int j = 0; j < 48; j++) begin
      tick();
      if (sclk_b !== 1'(((j / 3) % 2))) bad++;
      if (cs_b !== 1'b0) bad++;
      if (j % 6 == 3) got = {got[6:0], din_b};
    end
    chk("t5_phases", bad, 0);
    chk("t5_byte", got, 8'hA5);
    chk("t5_dc", dc_b, 1);
    tick(); chk("t5_hold1_cs", cs_b, 0); chk("t5_hold1_clk", sclk_b, 0);
    tick(); chk("t5_hold2_cs", cs_b, 0);
    tick(); chk("t5_cs_up", cs_b, 1); chk("t5_busy", busy_b, 0);

    // Reset mid-byte with bytes queued
    mon_clear();
    wr_valid_a = 1'b1; wr_dc_a = DC_DATA;
    for (int i = 0; i < 5; i++) begin
      wr_byte_a = 8'(8'h81 + i);
      tick();
    end
    wr_valid_a = 1'b0;
    saved = 0;
    while (rise_cnt < 3 && saved < 100) begin tick(); saved++; end
    chk("t6_reach_bit3", rise_cnt, 3);
    rst_a = 1'b1;
    tick();
    chk("t6_cs", cs_a, 1); chk("t6_clk", sclk_a, 0); chk("t6_lvl", fifo_level_a, 0);
    chk("t6_busy", busy_a, 0); chk("t6_rdy", wr_ready_a, 1);
    rst_a = 1'b0;
    repeat (30) tick();
    chk("t6_no_edges", rise_cnt, 3);
    chk("t6_cs_idle", cs_a, 1);
    write_a(DC_DATA, 8'h5A);
    wait_idle_a(200);
    chk("t6_nbytes", rx_q.size(), 1);
    chk("t6_byte", rx_at(0), 9'h15A);

    chk("sclk_with_cs_high", cs_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
